// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART receive path.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;
  localparam int unsigned LAST_TICK  = 15;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop,
    StBreak
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with a one-entry holding register.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects sense) and parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  input  logic            rx_rd,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_valid,
  output logic            rx_done_tick,
  output logic            frame_err,
`ifdef UART_RX_PARITY_EN
  output logic            parity_err,
`endif
  output logic            overrun_err
);

  // s_cnt must also reach SB_TICK-1 for 1.5/2 stop-bit configurations.
  localparam int unsigned SMax = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int unsigned SW   = $clog2(SMax);
  localparam int unsigned NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  rx_state_e       state_q, state_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [DBIT-1:0] rx_dout_q, rx_dout_d;
  logic            rx_valid_q, rx_valid_d;
  logic            done_q, done_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            rxs;
  logic            commit;
  logic            stop_bad;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (rx),
    .q_o     (rxs)
  );

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic par_err_q, par_err_d;
  logic par_bad;
  assign par_bad = ((^shreg_q) ^ par_q) != PARITY_ODD[0];
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD[0];
`endif

  always_comb begin
    state_d  = state_q;
    s_cnt_d  = s_cnt_q;
    n_cnt_d  = n_cnt_q;
    shreg_d  = shreg_q;
    commit   = 1'b0;
    stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rxs) begin
          state_d = StStart;
          s_cnt_d = '0;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (s_cnt_q == SW'(MID_TICK)) begin
            // A start bit that is gone by mid-bit is treated as a glitch.
            if (!rxs) begin
              state_d = StData;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_cnt_q == SW'(LAST_TICK)) begin
            shreg_d = {rxs, shreg_q[DBIT-1:1]};
            s_cnt_d = '0;
            if (n_cnt_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = StPar;
`else
              state_d = StStop;
`endif
            end else begin
              n_cnt_d = n_cnt_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      StPar: begin
`ifdef UART_RX_PARITY_EN
        if (s_tick) begin
          if (s_cnt_q == SW'(LAST_TICK)) begin
            par_d   = rxs;
            s_cnt_d = '0;
            state_d = StStop;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
`else
        state_d = StIdle;
`endif
      end
      StStop: begin
        if (s_tick) begin
          if (s_cnt_q == SW'(SB_TICK - 1)) begin
            if (rxs) begin
              commit  = 1'b1;
              state_d = StIdle;
            end else begin
              stop_bad = 1'b1;
              state_d  = StBreak;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      StBreak: begin
        // Hold here until the line idles so a stuck-low line cannot retrigger.
        if (rxs) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rx_dout_d   = commit ? shreg_q : rx_dout_q;
    done_d      = commit;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (rx_rd) begin
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (commit) begin
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_rd) begin
        overrun_d = 1'b1;
      end
    end
    if (stop_bad) begin
      frame_err_d = 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_comb begin
    par_err_d = par_err_q;
    if (rx_rd) begin
      par_err_d = 1'b0;
    end
    if (commit && par_bad) begin
      par_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_q     <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      par_err_q <= par_err_d;
    end
  end

  assign parity_err = par_err_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      s_cnt_q     <= '0;
      n_cnt_q     <= '0;
      shreg_q     <= '0;
      rx_dout_q   <= '0;
      rx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_cnt_q     <= s_cnt_d;
      n_cnt_q     <= n_cnt_d;
      shreg_q     <= shreg_d;
      rx_dout_q   <= rx_dout_d;
      rx_valid_q  <= rx_valid_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_dout      = rx_dout_q;
  assign rx_valid     = rx_valid_q;
  assign rx_done_tick = done_q;
  assign frame_err    = frame_err_q;
  assign overrun_err  = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serial frames driven bit by bit, delivered bytes checked on rx_done_tick.
module tb_uart_rx;

  localparam int BIT_CLK = 256;  // 16 s_ticks of 16 clk each

  logic       clk;
  logic       reset_n;
  logic       rx;
  logic       s_tick;
  logic       rx_rd;
  logic [7:0] rx_dout;
  logic       rx_valid;
  logic       rx_done_tick;
  logic       frame_err;
  logic       overrun_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int         n_checks;
  int         n_errors;
  int         n_done;
  logic [7:0] sb[$];

  uart_rx dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .s_tick       (s_tick),
    .rx_rd        (rx_rd),
    .rx_dout      (rx_dout),
    .rx_valid     (rx_valid),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err   (parity_err),
`endif
    .overrun_err  (overrun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // s_tick changes just after the rising edge so it is stable around both edges.
  initial begin
    int tcnt;
    tcnt   = 0;
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt   = (tcnt + 1) % 16;
      s_tick = (tcnt == 0);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && rx_done_tick) begin
      n_done++;
      check_eq("sb_avail", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        check_eq("rx_dout", 32'(rx_dout), 32'(sb.pop_front()));
      end
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_lvl,
                            input logic with_par, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (with_par) drive_bit(par_bit);
    drive_bit(stop_lvl);
    rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] data);
    sb.push_back(data);
    send_frame(data, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pulse_rd();
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int done0;
    logic seen;
    n_checks = 0;
    n_errors = 0;
    n_done   = 0;
    reset_n  = 1'b0;
    rx       = 1'b1;
    rx_rd    = 1'b0;
    repeat (5) @(negedge clk);

    // Reset values
    check_eq("rst_dout", 32'(rx_dout), 0);
    check_eq("rst_valid", 32'(rx_valid), 0);
    check_eq("rst_done", 32'(rx_done_tick), 0);
    check_eq("rst_ferr", 32'(frame_err), 0);
    check_eq("rst_oerr", 32'(overrun_err), 0);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);

    // Basic frame
    send_good(8'hA5);
    repeat (4) @(negedge clk);
    check_eq("a5_sb_empty", 32'(sb.size()), 0);
    check_eq("a5_done_cnt", 32'(n_done), 1);
    check_eq("a5_valid", 32'(rx_valid), 1);
    check_eq("a5_ferr", 32'(frame_err), 0);
    check_eq("a5_oerr", 32'(overrun_err), 0);
    pulse_rd();
    check_eq("a5_rd_valid", 32'(rx_valid), 0);

    // Start-bit glitch of 4 ticks
    done0 = n_done;
    rx = 1'b0;
    repeat (64) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    check_eq("glitch_done", 32'(n_done), 32'(done0));
    check_eq("glitch_valid", 32'(rx_valid), 0);
    check_eq("glitch_ferr", 32'(frame_err), 0);

    // Bad stop bit, line held low, then a good frame
    done0 = n_done;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (2 * BIT_CLK) @(negedge clk);
    check_eq("brk_ferr", 32'(frame_err), 1);
    check_eq("brk_done", 32'(n_done), 32'(done0));
    check_eq("brk_valid", 32'(rx_valid), 0);
    rx = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    send_good(8'h55);
    repeat (4) @(negedge clk);
    check_eq("55_sb_empty", 32'(sb.size()), 0);
    check_eq("55_done_cnt", 32'(n_done), 32'(done0 + 1));
    check_eq("55_ferr_sticky", 32'(frame_err), 1);
    pulse_rd();
    check_eq("55_rd_ferr", 32'(frame_err), 0);

    // Overrun
    send_good(8'h11);
    send_good(8'h22);
    repeat (4) @(negedge clk);
    check_eq("ovr_sb_empty", 32'(sb.size()), 0);
    check_eq("ovr_oerr", 32'(overrun_err), 1);
    check_eq("ovr_valid", 32'(rx_valid), 1);
    pulse_rd();
    check_eq("ovr_rd_oerr", 32'(overrun_err), 0);
    check_eq("ovr_rd_valid", 32'(rx_valid), 0);

    // rx_rd in the commit cycle of the second byte
    send_good(8'h11);
    seen = 1'b0;
    fork
      send_good(8'h22);
      begin
        for (int i = 0; i < 12 * BIT_CLK; i++) begin
          @(negedge clk);
          if (dut.commit) begin
            seen = 1'b1;
            break;
          end
        end
        if (seen) begin
          rx_rd = 1'b1;
          @(negedge clk);
          rx_rd = 1'b0;
        end
      end
    join
    repeat (4) @(negedge clk);
    check_eq("rdc_commit_seen", 32'(seen), 1);
    check_eq("rdc_sb_empty", 32'(sb.size()), 0);
    check_eq("rdc_oerr", 32'(overrun_err), 0);
    check_eq("rdc_valid", 32'(rx_valid), 1);

    // Reset during bit 4 of 8'hF0
    done0 = n_done;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx = 1'b1;
    repeat (BIT_CLK / 2) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mrst_dout", 32'(rx_dout), 0);
    check_eq("mrst_valid", 32'(rx_valid), 0);
    check_eq("mrst_done", 32'(rx_done_tick), 0);
    check_eq("mrst_ferr", 32'(frame_err), 0);
    check_eq("mrst_oerr", 32'(overrun_err), 0);
    reset_n = 1'b1;
    repeat (5 * BIT_CLK) @(negedge clk);
    check_eq("mrst_no_partial", 32'(n_done), 32'(done0));
    send_good(8'h0F);
    repeat (4) @(negedge clk);
    check_eq("0f_sb_empty", 32'(sb.size()), 0);
    check_eq("0f_done_cnt", 32'(n_done), 32'(done0 + 1));
    check_eq("0f_valid", 32'(rx_valid), 1);
    pulse_rd();

`ifdef UART_RX_PARITY_EN
    // Even parity: 8'h07 has three ones, so parity bit 1 is correct
    sb.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("par_ok_sb_empty", 32'(sb.size()), 0);
    check_eq("par_ok_perr", 32'(parity_err), 0);
    pulse_rd();
    sb.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("par_bad_sb_empty", 32'(sb.size()), 0);
    check_eq("par_bad_perr", 32'(parity_err), 1);
    check_eq("par_bad_dout", 32'(rx_dout), 32'h07);
    pulse_rd();
    check_eq("par_rd_perr", 32'(parity_err), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
